// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers software bytes in a FIFO and launches one UART frame at a time,
// with an optional idle gap (in baud ticks) between frames.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_data_i,
  input  logic                          flush_i,
  input  logic                          enable_i,
  input  logic [GAP_W-1:0]              gap_ticks_i,
  input  logic                          ovf_clr_i,
  input  logic                          tx_tick,
  input  logic                          tx_done_i,
  output logic [31:0]                   tx_data_o,
  output logic                          start_tx_o,
  output logic                          fifo_empty_o,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          frame_sent_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP} state_t;
  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       data_q;
  logic             ovf_q;
  logic             empty, full, push, pop, ovf_set;
  assign empty   = level_q == '0;
  assign full    = level_q == LW'(FIFO_DEPTH);
  assign push    = wr_en_i && !full && !flush_i;
  assign pop     = state_q == IDLE && enable_i && !empty;
  // a write lost to a flush is intentional, so only a full FIFO counts as overflow
  assign ovf_set = wr_en_i && full && !flush_i;
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE:      state_d = pop ? LAUNCH : IDLE;
      LAUNCH:    state_d = WAIT_ACK;
      WAIT_ACK:  state_d = tx_done_i ? WAIT_ACK : WAIT_DONE;
      WAIT_DONE: if (tx_done_i) begin
        state_d = (gap_ticks_i != '0) ? GAP : IDLE;
        gap_d   = gap_ticks_i;
      end
      GAP:       if (tx_tick) begin
        gap_d   = gap_q - GAP_W'(1);
        state_d = (gap_q == GAP_W'(1)) ? IDLE : GAP;
      end
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_ptr_q <= flush_i ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= flush_i ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_q  <= flush_i ? '0 : level_q + LW'(push) - LW'(pop);
      data_q   <= pop ? mem_q[rd_ptr_q] : data_q;
      ovf_q    <= ovf_set | (ovf_q & ~ovf_clr_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
  assign tx_data_o    = {24'b0, data_q};
  assign start_tx_o   = state_q == LAUNCH;
  assign frame_sent_o = state_q == WAIT_DONE && tx_done_i;
  assign busy_o       = state_q != IDLE;
  assign fifo_empty_o = empty;
  assign fifo_full_o  = full;
  assign fifo_level_o = level_q;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: table-driven FIFO checks plus scoreboarded frame launches against a
// simple transmitter model with a controllable done flag.
module tb_uart_tx_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [7:0]  wr_data_i = 8'h00;
  logic        flush_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [7:0]  gap_ticks_i = 8'd0;
  logic        ovf_clr_i = 1'b0;
  logic        tx_tick;
  logic        tx_done_i = 1'b1;
  logic [31:0] tx_data_o;
  logic        start_tx_o, fifo_empty_o, fifo_full_o, busy_o, overflow_o, frame_sent_o;
  logic [4:0]  fifo_level_o;

  uart_tx_sched #(.FIFO_DEPTH(16), .GAP_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .flush_i(flush_i),
    .enable_i(enable_i), .gap_ticks_i(gap_ticks_i), .ovf_clr_i(ovf_clr_i), .tx_tick(tx_tick),
    .tx_done_i(tx_done_i), .tx_data_o(tx_data_o), .start_tx_o(start_tx_o),
    .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o), .fifo_level_o(fifo_level_o),
    .busy_o(busy_o), .overflow_o(overflow_o), .frame_sent_o(frame_sent_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_sent = 0;
  int gap_meas = -1;
  logic [7:0] q[$];
  logic hold = 1'b0;
  logic [2:0] tx_cnt = 3'd0;
  logic [1:0] tdiv = 2'd0;

  // transmitter model: done drops after a launch, rises after a few cycles unless held
  always @(posedge clk) begin
    if (start_tx_o) begin
      tx_done_i <= 1'b0;
      tx_cnt    <= 3'd4;
    end else if (tx_cnt != 3'd0) tx_cnt <= tx_cnt - 3'd1;
    else if (!hold) tx_done_i <= 1'b1;
  end
  always @(posedge clk) tdiv <= (tdiv == 2'd2) ? 2'd0 : tdiv + 2'd1;
  assign tx_tick = (tdiv == 2'd2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en_i = 1'b1;
    wr_data_i = b;
    q.push_back(b);
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && (q.size() != 0 || busy_o); k++) step();
    chk("wait_idle", {31'b0, busy_o}, 32'd0);
  endtask

  // monitor: scoreboard pop on each launch, count frames and gap ticks
  initial begin
    logic prev_start = 1'b0;
    logic counting = 1'b0;
    int ticks = 0;
    forever begin
      @(negedge clk);
      if (frame_sent_o) begin
        n_sent++;
        counting = 1'b1;
        ticks = 0;
      end else if (start_tx_o) begin
        n_start++;
        chk("start_width", {31'b0, prev_start}, 32'd0);
        chk("start_has_data", {31'b0, q.size() != 0}, 32'd1);
        if (q.size() != 0) chk("tx_data", tx_data_o, {24'b0, q.pop_front()});
        if (counting) gap_meas = ticks;
        counting = 1'b0;
      end else if (counting && tx_tick) ticks++;
      prev_start = start_tx_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    int         lvl;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vt[21];

  initial begin
    int s, f, mdl_lvl;
    for (int i = 0; i < 18; i++)
      vt[i] = '{1'b1, 8'(8'h40 + i), 1'b0, (i < 16) ? i + 1 : 16, 1'(i >= 15), 1'(i >= 16)};
    vt[18] = '{1'b1, 8'hEE, 1'b1, 16, 1'b1, 1'b1};
    vt[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0};
    vt[20] = '{1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0};

    step(); step();
    rst = 1'b0;
    chk("rst_start", {31'b0, start_tx_o}, 32'd0);
    chk("rst_data", tx_data_o, 32'd0);
    chk("rst_empty", {31'b0, fifo_empty_o}, 32'd1);
    chk("rst_full", {31'b0, fifo_full_o}, 32'd0);
    chk("rst_level", {27'b0, fifo_level_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_o}, 32'd0);
    chk("rst_sent", {31'b0, frame_sent_o}, 32'd0);

    // single byte, latency write -> start = 2 cycles
    enable_i = 1'b1;
    wr_byte(8'hA5);
    chk("t1_start_n1", {31'b0, start_tx_o}, 32'd0);
    chk("t1_level_n1", {27'b0, fifo_level_o}, 32'd1);
    step();
    chk("t1_start_n2", {31'b0, start_tx_o}, 32'd1);
    chk("t1_data", tx_data_o, 32'h000000A5);
    chk("t1_empty", {31'b0, fifo_empty_o}, 32'd1);
    step();
    chk("t1_start_n3", {31'b0, start_tx_o}, 32'd0);
    wait_idle(100);
    chk("t1_sent", n_sent, 32'd1);
    chk("t1_starts", n_start, 32'd1);

    // three bytes queued then drained in order
    enable_i = 1'b0;
    s = n_start;
    wr_byte(8'h11); chk("t2_lvl1", {27'b0, fifo_level_o}, 32'd1);
    wr_byte(8'h22); chk("t2_lvl2", {27'b0, fifo_level_o}, 32'd2);
    wr_byte(8'h33); chk("t2_lvl3", {27'b0, fifo_level_o}, 32'd3);
    enable_i = 1'b1;
    step();
    chk("t2_lvl_pop", {27'b0, fifo_level_o}, 32'd2);
    wait_idle(200);
    chk("t2_starts", n_start - s, 32'd3);
    chk("t2_empty", {31'b0, fifo_empty_o}, 32'd1);

    // table: fill past full with launching disabled, overflow set/clear priority
    enable_i = 1'b0;
    mdl_lvl = 0;
    for (int i = 0; i < 21; i++) begin
      wr_en_i = vt[i].wr;
      wr_data_i = vt[i].d;
      ovf_clr_i = vt[i].clr;
      if (vt[i].wr && mdl_lvl < 16) begin
        q.push_back(vt[i].d);
        mdl_lvl++;
      end
      step();
      chk($sformatf("v%0d_level", i), {27'b0, fifo_level_o}, vt[i].lvl);
      chk($sformatf("v%0d_full", i), {31'b0, fifo_full_o}, {31'b0, vt[i].full});
      chk($sformatf("v%0d_empty", i), {31'b0, fifo_empty_o}, {31'b0, vt[i].lvl == 0});
      chk($sformatf("v%0d_ovf", i), {31'b0, overflow_o}, {31'b0, vt[i].ovf});
    end
    wr_en_i = 1'b0;
    ovf_clr_i = 1'b0;
    s = n_start;
    enable_i = 1'b1;
    wait_idle(400);
    chk("t3_starts", n_start - s, 32'd16);
    chk("t3_empty", {31'b0, fifo_empty_o}, 32'd1);

    // programmable gap; a mid-gap change must not matter
    enable_i = 1'b0;
    gap_ticks_i = 8'd4;
    wr_byte(8'h61);
    wr_byte(8'h62);
    s = n_start;
    f = n_sent;
    enable_i = 1'b1;
    for (int k = 0; k < 100 && n_sent == f; k++) step();
    chk("t4_first_sent", {31'b0, n_sent > f}, 32'd1);
    step(); step();
    gap_ticks_i = 8'd9;
    for (int k = 0; k < 100 && n_start < s + 2; k++) step();
    chk("t4_second_start", n_start - s, 32'd2);
    chk("t4_gap_ticks", gap_meas, 32'd4);
    wait_idle(200);
    gap_ticks_i = 8'd0;

    // flush while a frame waits for done
    hold = 1'b1;
    enable_i = 1'b0;
    for (int i = 0; i < 6; i++) wr_byte(8'(8'h81 + i));
    s = n_start;
    f = n_sent;
    enable_i = 1'b1;
    for (int k = 0; k < 50 && n_start == s; k++) step();
    step(); step(); step(); step();
    chk("t5_level", {27'b0, fifo_level_o}, 32'd5);
    chk("t5_busy", {31'b0, busy_o}, 32'd1);
    flush_i = 1'b1;
    wr_en_i = 1'b1;
    wr_data_i = 8'h77;
    step();
    flush_i = 1'b0;
    wr_en_i = 1'b0;
    q.delete();
    chk("t5_flush_level", {27'b0, fifo_level_o}, 32'd0);
    chk("t5_flush_empty", {31'b0, fifo_empty_o}, 32'd1);
    chk("t5_flush_ovf", {31'b0, overflow_o}, 32'd0);
    hold = 1'b0;
    wait_idle(100);
    for (int k = 0; k < 10; k++) step();
    chk("t5_sent", n_sent - f, 32'd1);
    chk("t5_starts", n_start - s, 32'd1);
    chk("t5_level_end", {27'b0, fifo_level_o}, 32'd0);

    // reset while a frame waits for done, then a normal launch
    hold = 1'b1;
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h91 + i));
    s = n_start;
    enable_i = 1'b1;
    for (int k = 0; k < 50 && n_start == s; k++) step();
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk("t6_start", {31'b0, start_tx_o}, 32'd0);
    chk("t6_data", tx_data_o, 32'd0);
    chk("t6_empty", {31'b0, fifo_empty_o}, 32'd1);
    chk("t6_full", {31'b0, fifo_full_o}, 32'd0);
    chk("t6_level", {27'b0, fifo_level_o}, 32'd0);
    chk("t6_busy", {31'b0, busy_o}, 32'd0);
    chk("t6_ovf", {31'b0, overflow_o}, 32'd0);
    chk("t6_sent", {31'b0, frame_sent_o}, 32'd0);
    hold = 1'b0;
    step(); step(); step();
    s = n_start;
    wr_byte(8'h5A);
    wait_idle(100);
    chk("t6_relaunch", n_start - s, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
